// File: rtl/rr_arbiter_8_pkg.sv
// rtl/rr_arbiter_8_pkg.sv - shared state type and round-robin winner search
package rr_arbiter_8_pkg;
  `include "arb_defs.vh"

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT,
    S_GAP   = ST_GAP
  } state_t;

  // First set request at or after ptr, wrapping 7->0; ptr is returned when req is zero.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/arb_defs.vh
// rtl/arb_defs.vh - state codes and default limits for the round-robin arbiter
`ifndef ARB_DEFS_VH
`define ARB_DEFS_VH
localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_GRANT = 2'd1;
localparam logic [1:0] ST_GAP   = 2'd2;
localparam int MAX_HOLD_DEFAULT = 15;
localparam int HOLD_W_DEFAULT   = 4;
`endif

// File: rtl/decoder_3_8_behav.sv
// rtl/decoder_3_8_behav.sv - behavioral 3-to-8 one-hot decoder with enable
module decoder_3_8_behav (
  input  logic [2:0] I,
  input  logic       en,
  output logic [7:0] y
);
  always_comb begin
    y = 8'h00;
    if (en) y[I] = 1'b1;
  end
endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with done/drop/hold-limit release
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int HOLD_W   = HOLD_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);
  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                tmo_q, tmo_d;
  logic [2:0]          winner;
  logic                limit;
  logic                owner_req;

  assign winner    = rr_pick(req, ptr_q);
  assign limit     = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign owner_req = req[idx_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      ptr_q   <= 3'd0;
      hold_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (|req) begin
          state_d = S_GRANT;
          idx_d   = winner;
          hold_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        hold_d = hold_q + 1'b1;
        if (done || !owner_req || limit) begin
          state_d = S_GAP;
          ptr_d   = idx_q + 3'd1;
          // Only a pure hold-limit release is reported as a timeout.
          tmo_d   = limit && !done && owner_req;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  decoder_3_8_behav u_dec (
    .I  (idx_q),
    .en (state_q == S_GRANT),
    .y  (gnt)
  );

  assign gnt_idx = idx_q;
  assign busy    = (state_q == S_GRANT);
  assign timeout = tmo_q;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;
  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int         errors;
  int         checks;
  int         tmo_seen;
  logic       busy_prev;
  logic [2:0] exp_q[$];

  rr_arbiter_8 #(.MAX_HOLD(15), .HOLD_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant monitor: each new grant is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      busy_prev <= 1'b0;
    end else begin
      chk("onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      if (busy && !busy_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", {29'd0, gnt_idx}, 32'hFFFF_FFFF);
        end else begin
          logic [2:0] e;
          logic [7:0] oh;
          e  = exp_q.pop_front();
          oh = 8'h01 << e;
          chk("grant_idx", {29'd0, gnt_idx}, {29'd0, e});
          chk("grant_vec", {24'd0, gnt}, {24'd0, oh});
        end
      end
      if (timeout) tmo_seen <= tmo_seen + 1;
      busy_prev <= busy;
    end
  end

  initial begin
    errors   = 0;
    checks   = 0;
    tmo_seen = 0;
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {24'd0, gnt}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_idx", {29'd0, gnt_idx}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);

    exp_q.push_back(3'd0);
    rst = 1'b0;
    tick();
    chk("first_gnt", {24'd0, gnt}, 32'h01);

    // Full rotation with done two cycles into each grant
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(3'(k % 8));
      tick();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("rot_gap_gnt", {24'd0, gnt}, 32'h00);
      chk("rot_gap_tmo", {31'd0, timeout}, 32'd0);
      tick();
    end

    // Sole requester 4 held to the hold limit
    req = 8'h10;
    exp_q.push_back(3'd4);
    tick();
    chk("drop0_gap_gnt", {24'd0, gnt}, 32'h00);
    chk("drop0_tmo", {31'd0, timeout}, 32'd0);
    tick();
    chk("hold_gnt", {24'd0, gnt}, 32'h10);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("hold_gnt", {24'd0, gnt}, 32'h10);
    end
    exp_q.push_back(3'd4);
    tick();
    chk("limit_gap_gnt", {24'd0, gnt}, 32'h00);
    chk("limit_tmo", {31'd0, timeout}, 32'd1);
    tick();
    chk("rewin_gnt", {24'd0, gnt}, 32'h10);
    chk("rewin_tmo", {31'd0, timeout}, 32'd0);

    // Grant 6, then 7 must beat 0, then 0, then 7 again
    req = 8'h40;
    exp_q.push_back(3'd6);
    tick();
    tick();
    chk("g6", {24'd0, gnt}, 32'h40);
    req = 8'h81;
    exp_q.push_back(3'd7);
    tick();
    tick();
    chk("g7_first", {24'd0, gnt}, 32'h80);
    exp_q.push_back(3'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("g0_after7", {24'd0, gnt}, 32'h01);
    exp_q.push_back(3'd7);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("g7_wrap", {24'd0, gnt}, 32'h80);

    // Owner 3 drops mid-grant; ptr=4 makes 4 beat 0
    req = 8'h08;
    exp_q.push_back(3'd3);
    tick();
    tick();
    chk("g3", {24'd0, gnt}, 32'h08);
    tick();
    tick();
    req = 8'h11;
    exp_q.push_back(3'd4);
    tick();
    chk("drop3_gap_gnt", {24'd0, gnt}, 32'h00);
    chk("drop3_tmo", {31'd0, timeout}, 32'd0);
    tick();
    chk("g4_ptr", {24'd0, gnt}, 32'h10);

    // done coincident with the hold limit
    for (int i = 1; i < 15; i++) tick();
    chk("coinc_pre", {24'd0, gnt}, 32'h10);
    done = 1'b1;
    exp_q.push_back(3'd0);
    tick();
    done = 1'b0;
    chk("coinc_gap_gnt", {24'd0, gnt}, 32'h00);
    chk("coinc_tmo", {31'd0, timeout}, 32'd0);
    tick();
    chk("g0_after4", {24'd0, gnt}, 32'h01);

    // Asynchronous reset mid-grant, then restart from ptr=0
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_gnt", {24'd0, gnt}, 32'h00);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_idx", {29'd0, gnt_idx}, 32'd0);
    tick();
    req = 8'h81;
    exp_q.push_back(3'd0);
    rst = 1'b0;
    tick();
    chk("restart_gnt", {24'd0, gnt}, 32'h01);
    tick();

    chk("queue_empty", exp_q.size(), 32'd0);
    chk("timeout_count", tmo_seen, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
